// File: rtl/camera_alarme.sv
// camera_alarme: qualifies per-camera motion against the rotator's active-group
// mask, keeps a sticky mask of unacknowledged detections, presents one alarm at
// a time (lowest camera index first) until acknowledged, and keeps a
// saturating count of captured events.
module camera_alarme #(
  parameter int NBITS_COUNT = 9,
  parameter int NBITS_EVT   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NBITS_COUNT-1:0] cameras_ativas,
  input  logic [NBITS_COUNT-1:0] movimento,
  input  logic                   ack,
  output logic                   alarme,
  output logic [3:0]             camera_id,
  output logic [NBITS_COUNT-1:0] pendente,
  output logic [NBITS_EVT-1:0]   total_eventos
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ALARME = 2'd1,
    PAUSA  = 2'd2
  } state_t;

  localparam logic [NBITS_EVT:0] EVT_MAX = {1'b0, {NBITS_EVT{1'b1}}};

  state_t                 state;
  logic [NBITS_COUNT-1:0] det;
  logic [NBITS_COUNT-1:0] clr;
  logic [NBITS_COUNT-1:0] next_pend;
  logic [NBITS_COUNT-1:0] new_bits;
  logic [NBITS_EVT:0]     sum;
  logic [NBITS_EVT-1:0]   next_total;
  logic [3:0]             lowest_pend;

  // Number of set bits, one extra bit wide so the saturating add cannot wrap.
  function automatic logic [NBITS_EVT:0] popcount(input logic [NBITS_COUNT-1:0] x);
    logic [NBITS_EVT:0] c;
    c = '0;
    for (int i = 0; i < NBITS_COUNT; i++) c = c + (NBITS_EVT+1)'(x[i]);
    return c;
  endfunction

  // Index of the lowest set bit; scanning downward lets the lowest index win.
  function automatic logic [3:0] lowest(input logic [NBITS_COUNT-1:0] x);
    logic [3:0] r;
    r = '0;
    for (int i = NBITS_COUNT - 1; i >= 0; i--) if (x[i]) r = 4'(i);
    return r;
  endfunction

  // One-hot mask of a camera index.
  function automatic logic [NBITS_COUNT-1:0] one_hot(input logic [3:0] id);
    logic [NBITS_COUNT-1:0] r;
    r = '0;
    for (int i = 0; i < NBITS_COUNT; i++) if (4'(i) == id) r[i] = 1'b1;
    return r;
  endfunction

  // Next pending mask and event count; a bit cleared by ack and re-detected in
  // the same cycle stays pending and is counted as a new event.
  always_comb begin
    // NOTE: every signal gets a value on every path before any condition, so
    // no latch can be inferred.
    det = movimento & cameras_ativas;
    clr = '0;
    if (state == ALARME && ack) clr = one_hot(camera_id);
    next_pend   = (pendente & ~clr) | det;
    new_bits    = det & ~(pendente & ~clr);
    sum         = {1'b0, total_eventos} + popcount(new_bits);
    next_total  = (sum > EVT_MAX) ? EVT_MAX[NBITS_EVT-1:0] : sum[NBITS_EVT-1:0];
    lowest_pend = lowest(next_pend);
  end

  // Alarm FSM with registered outputs; reset discards same-cycle detections.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state         <= IDLE;
      alarme        <= 1'b0;
      camera_id     <= '0;
      pendente      <= '0;
      total_eventos <= '0;
    end else begin
      pendente      <= next_pend;
      total_eventos <= next_total;
      case (state)
        IDLE: begin
          if (|next_pend) begin
            state     <= ALARME;
            alarme    <= 1'b1;
            camera_id <= lowest_pend;
          end
        end
        ALARME: begin
          if (ack) begin
            state  <= PAUSA;
            alarme <= 1'b0;
          end
        end
        PAUSA: begin
          if (|next_pend) begin
            state     <= ALARME;
            alarme    <= 1'b1;
            camera_id <= lowest_pend;
          end else begin
            state  <= IDLE;
            alarme <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          alarme <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_camera_alarme.sv
// Self-checking bench for camera_alarme: directed scenarios followed by random
// traffic, all compared against a behavioural model of the alarm rules.
module tb_camera_alarme;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] cameras_ativas;
  logic [8:0] movimento;
  logic       ack;
  logic       alarme;
  logic [3:0] camera_id;
  logic [8:0] pendente;
  logic [7:0] total_eventos;

  int errors = 0;
  int checks = 0;

  // Behavioural model: an alarm is shown or not, for some camera, over a set
  // of pending cameras, plus a capped event tally.
  logic       m_alarm;
  logic [3:0] m_id;
  logic [8:0] m_pend;
  int         m_total;

  camera_alarme #(.NBITS_COUNT(9), .NBITS_EVT(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .cameras_ativas(cameras_ativas),
    .movimento     (movimento),
    .ack           (ack),
    .alarme        (alarme),
    .camera_id     (camera_id),
    .pendente      (pendente),
    .total_eventos (total_eventos)
  );

  always #5 clk = ~clk;

  // Apply the alarm rules for one clock to the model.
  task automatic model_step(input logic [8:0] m, input logic [8:0] a,
                            input logic k, input logic r);
    logic [8:0] det;
    logic [8:0] kept;
    int         fresh;
    bit         found;
    if (r) begin
      m_alarm = 1'b0; m_id = 4'd0; m_pend = 9'd0; m_total = 0;
      return;
    end
    det  = m & a;
    kept = m_pend;
    if (m_alarm && k) kept[m_id] = 1'b0;
    fresh = 0;
    for (int i = 0; i < 9; i++) if (det[i] && !kept[i]) fresh++;
    m_total = (m_total + fresh > 255) ? 255 : m_total + fresh;
    m_pend  = kept | det;
    if (m_alarm) begin
      if (k) m_alarm = 1'b0;
    end else if (m_pend != 0) begin
      m_alarm = 1'b1;
      found   = 1'b0;
      for (int i = 0; i < 9; i++)
        if (!found && m_pend[i]) begin
          m_id  = 4'(i);
          found = 1'b1;
        end
    end
  endtask

  task automatic compare_model(input string tag);
    checks++;
    assert (alarme === m_alarm) else begin
      errors++; $error("FAIL %s alarme got=%0b exp=%0b", tag, alarme, m_alarm);
    end
    checks++;
    assert (pendente === m_pend) else begin
      errors++; $error("FAIL %s pendente got=%03h exp=%03h", tag, pendente, m_pend);
    end
    checks++;
    assert (int'(total_eventos) === m_total) else begin
      errors++; $error("FAIL %s total_eventos got=%0d exp=%0d", tag, total_eventos, m_total);
    end
    checks++;
    assert (camera_id === m_id) else begin
      errors++; $error("FAIL %s camera_id got=%0d exp=%0d", tag, camera_id, m_id);
    end
  endtask

  // Drive one cycle of inputs, clock it, then compare outputs with the model.
  task automatic step(input string tag, input logic [8:0] m, input logic [8:0] a,
                      input logic k, input logic r);
    movimento = m; cameras_ativas = a; ack = k; reset = r;
    model_step(m, a, k, r);
    @(posedge clk);
    #1;
    compare_model(tag);
  endtask

  task automatic expect_val(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++; $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  initial begin
    logic [8:0] rm;
    logic [8:0] ra;
    logic       rk;
    logic       rr;
    movimento = '0; cameras_ativas = '0; ack = 1'b0; reset = 1'b1;
    m_alarm = 1'b0; m_id = 4'd0; m_pend = 9'd0; m_total = 0;

    // Reset state.
    step("reset", 9'h000, 9'h000, 1'b0, 1'b1);
    step("reset2", 9'h000, 9'h000, 1'b0, 1'b1);
    expect_val("reset_alarme", int'(alarme), 0);
    expect_val("reset_total", int'(total_eventos), 0);

    // Single in-group detection, then hold without ack.
    step("cam1", 9'h002, 9'h007, 1'b0, 1'b0);
    expect_val("cam1_alarme", int'(alarme), 1);
    expect_val("cam1_id", int'(camera_id), 1);
    expect_val("cam1_pend", int'(pendente), 2);
    expect_val("cam1_total", int'(total_eventos), 1);
    for (int i = 0; i < 10; i++) step("cam1_hold", 9'h000, 9'h007, 1'b0, 1'b0);
    expect_val("cam1_hold_id", int'(camera_id), 1);

    // Out-of-group motion is ignored.
    step("rst_a", 9'h000, 9'h000, 1'b0, 1'b1);
    step("outgrp", 9'h001, 9'h038, 1'b0, 1'b0);
    expect_val("outgrp_alarme", int'(alarme), 0);
    expect_val("outgrp_pend", int'(pendente), 0);
    expect_val("outgrp_total", int'(total_eventos), 0);

    // Two detections in one cycle, served lowest first with a gap between.
    step("rst_b", 9'h000, 9'h000, 1'b0, 1'b1);
    step("two", 9'h140, 9'h1C0, 1'b0, 1'b0);
    expect_val("two_id", int'(camera_id), 6);
    expect_val("two_total", int'(total_eventos), 2);
    step("ack6", 9'h000, 9'h1C0, 1'b1, 1'b0);
    expect_val("ack6_gap", int'(alarme), 0);
    step("next8", 9'h000, 9'h1C0, 1'b0, 1'b0);
    expect_val("next8_alarme", int'(alarme), 1);
    expect_val("next8_id", int'(camera_id), 8);
    step("ack8", 9'h000, 9'h1C0, 1'b1, 1'b0);
    step("idle8", 9'h000, 9'h1C0, 1'b0, 1'b0);
    expect_val("idle8_pend", int'(pendente), 0);
    expect_val("idle8_alarme", int'(alarme), 0);
    step("idle8b", 9'h000, 9'h1C0, 1'b1, 1'b0);
    expect_val("ack_in_idle", int'(alarme), 0);

    // Ack coinciding with re-detection of the same camera: set wins.
    step("rst_c", 9'h000, 9'h000, 1'b0, 1'b1);
    step("re_set", 9'h002, 9'h007, 1'b0, 1'b0);
    step("re_ack", 9'h002, 9'h007, 1'b1, 1'b0);
    expect_val("re_pend", int'(pendente), 2);
    expect_val("re_total", int'(total_eventos), 2);
    expect_val("re_gap", int'(alarme), 0);
    step("re_back", 9'h000, 9'h007, 1'b0, 1'b0);
    expect_val("re_back_alarme", int'(alarme), 1);
    expect_val("re_back_id", int'(camera_id), 1);

    // Saturation of the event counter.
    step("rst_d", 9'h000, 9'h000, 1'b0, 1'b1);
    for (int i = 0; i < 300; i++) begin
      step("sat_det", 9'h001, 9'h007, 1'b0, 1'b0);
      step("sat_ack", 9'h000, 9'h007, 1'b1, 1'b0);
    end
    expect_val("sat_total", int'(total_eventos), 255);
    step("sat_more", 9'h001, 9'h007, 1'b0, 1'b0);
    expect_val("sat_hold", int'(total_eventos), 255);

    // Reset in the middle of an alarm with pending cameras 5 and 7.
    step("rst_e", 9'h000, 9'h000, 1'b0, 1'b1);
    step("p5", 9'h020, 9'h038, 1'b0, 1'b0);
    step("p7", 9'h080, 9'h1C0, 1'b0, 1'b0);
    expect_val("p_pend", int'(pendente), 9'h0A0);
    expect_val("p_alarme", int'(alarme), 1);
    step("mid_rst", 9'h1FF, 9'h1FF, 1'b0, 1'b1);
    expect_val("mid_rst_alarme", int'(alarme), 0);
    expect_val("mid_rst_pend", int'(pendente), 0);
    expect_val("mid_rst_id", int'(camera_id), 0);
    expect_val("mid_rst_total", int'(total_eventos), 0);
    step("post_rst", 9'h000, 9'h1FF, 1'b0, 1'b0);
    expect_val("post_rst_idle", int'(alarme), 0);

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      rm = 9'($urandom & $urandom & $urandom);
      case ($urandom_range(0, 3))
        0:       ra = 9'h007;
        1:       ra = 9'h038;
        2:       ra = 9'h1C0;
        default: ra = 9'($urandom);
      endcase
      rk = ($urandom_range(0, 3) == 0);
      rr = ($urandom_range(0, 80) == 0);
      step("rand", rm, ra, rk, rr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
